// File: rtl/rr_arb_pkg.sv
// Shared types and helpers for the 8-way round-robin arbiter.
// Consumed by rr_arbiter_8; the optional hold timeout is selected there by RR_ARB_TIMEOUT_EN.
package rr_arb_pkg;

  localparam int NUM_REQ = 8;
  localparam int IDX_W   = 3;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } arb_state_e;

  // First set request bit when scanning ptr, ptr+1, ... ptr+7 (mod 8); 0 if none.
  function automatic logic [IDX_W-1:0] rr_pick(input logic [NUM_REQ-1:0] req,
                                               input logic [IDX_W-1:0]   ptr);
    logic [IDX_W-1:0] idx;
    logic             found;
    rr_pick = '0;
    found   = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      idx = ptr + IDX_W'(i);
      if (!found && req[idx]) begin
        rr_pick = idx;
        found   = 1'b1;
      end
    end
  endfunction

endpackage

// File: rtl/decoder_3to8.sv
// Plain 3-to-8 binary-to-one-hot decoder shared across the team's select logic.
module decoder_3to8 (
  input  logic [2:0] in_i,
  output logic [7:0] out_o
);

  always_comb out_o = 8'b0000_0001 << in_i;

endmodule

// File: rtl/rr_arbiter_8.sv
// Round-robin arbiter for eight requesters with a registered binary grant index.
// Define RR_ARB_TIMEOUT_EN to build the hold counter that revokes grants after MAX_HOLD cycles.
module rr_arbiter_8
  import rr_arb_pkg::*;
#(
  parameter int MAX_HOLD = 15,
  parameter int HOLD_W   = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               en,
  input  logic [NUM_REQ-1:0] req,
  output logic [NUM_REQ-1:0] gnt,
  output logic [IDX_W-1:0]   gnt_idx,
  output logic               gnt_valid,
  output logic               timeout
);

  arb_state_e         state_q, state_d;
  logic [IDX_W-1:0]   ptr_q, ptr_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic               owner_req;
  logic               hold_expired;
  logic               revoke;
  logic [NUM_REQ-1:0] gnt_raw;

  assign owner_req = req[idx_q];

  // NOTE: every signal driven in always_comb gets a default first, so no latch is inferred.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    idx_d   = idx_q;
    revoke  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (en && (|req)) begin
          state_d = ST_GRANT;
          idx_d   = rr_pick(req, ptr_q);
        end
      end
      ST_GRANT: begin
        // A release on the expiry edge counts as a normal release, not a timeout.
        if (!owner_req || hold_expired) begin
          state_d = ST_IDLE;
          ptr_d   = idx_q + 1'b1;
          idx_d   = '0;
          revoke  = owner_req;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: sequential state is updated with non-blocking assignments only.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      ptr_q   <= '0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      idx_q   <= idx_d;
    end
  end

`ifdef RR_ARB_TIMEOUT_EN
  logic [HOLD_W-1:0] hold_q, hold_d;
  logic              timeout_q;

  // Counter sits at 0 while idle, so it always starts a grant from 0.
  always_comb hold_d = (state_q == ST_GRANT) ? hold_q + 1'b1 : '0;
  assign hold_expired = (state_q == ST_GRANT) && (hold_q == HOLD_W'(MAX_HOLD - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_q    <= '0;
      timeout_q <= 1'b0;
    end else begin
      hold_q    <= hold_d;
      timeout_q <= revoke;
    end
  end

  assign timeout = timeout_q;
`else
  logic unused_cfg;
  assign unused_cfg   = (MAX_HOLD > HOLD_W) | revoke;
  assign hold_expired = 1'b0;
  assign timeout      = 1'b0;
`endif

  decoder_3to8 u_dec (
    .in_i  (idx_q),
    .out_o (gnt_raw)
  );

  assign gnt_valid = (state_q == ST_GRANT);
  assign gnt_idx   = idx_q;
  assign gnt       = gnt_raw & {NUM_REQ{gnt_valid}};

endmodule

// File: doc/rr_arbiter_8.md
# rr_arbiter_8

Round-robin arbiter sharing one 8-way resource between eight requesters. It registers a binary grant index and decodes it into a one-hot grant vector through the team's 3-to-8 decoder. Each grant is held until the owner drops its request, or until an optional hold timeout expires. The block sits in front of any resource addressed by a 3-to-8 select, and is the single point that decides which requester drives it.

## Interface
- `MAX_HOLD`, default 15: maximum grant length in cycles; only used when the timeout is compiled in; legal range 1..2^HOLD_W-1.
- `HOLD_W`, default 4: width of the hold counter.
- `clk`  in  1  clock; all state changes on its rising edge.
- `rst_n`  in  1  reset; asynchronous, active-low.
- `en`  in  1  arbiter enable; gates new grants only.
- `req`  in  8  request vector; bit i is requester i.
- `gnt`  out  8  one-hot grant; all zero when no grant is active.
- `gnt_idx`  out  3  binary index of the current owner; 0 when idle.
- `gnt_valid`  out  1  a grant is active.
- `timeout`  out  1  one-cycle pulse when a grant was revoked by the timeout.

## Operation
- State machine with two states:
  - IDLE: no grant active.
  - GRANT: grant active and held.
- Round-robin pointer `ptr` (3 bits). The search order is ptr, ptr+1, …, ptr+7, all mod 8. The first set `req` bit in that order wins.
- IDLE → GRANT: when `en`=1 and `req`≠0. On the same edge, the winner is loaded into `gnt_idx` and `gnt_valid` goes to 1.
- GRANT → IDLE: when `req[gnt_idx]`=0 at the edge (normal release). On that edge:
  - `ptr` ← gnt_idx+1 mod 8, so 7 wraps to 0.
  - `gnt_valid` and `gnt` clear.
  - `gnt_idx` goes to 0.
- Only the owner's request bit matters in GRANT. Changes on other `req` bits are ignored until the next IDLE cycle.
- `en`=0 never revokes an active grant. It only holds the FSM in IDLE.
- If `en`=0 while in IDLE, no grant is issued and `ptr` is unchanged.
- `gnt` is a pure decode of the registered `gnt_idx`, qualified by `gnt_valid`. It is never more than one-hot.
- A requester that keeps `req` high after a timeout is treated like any other requester in the next round-robin pass.

## Timing
- Reset values, applied asynchronously: state=IDLE, `ptr`=0, `gnt`=0, `gnt_idx`=0, `gnt_valid`=0, `timeout`=0, hold counter=0.
- Grant latency: a request sampled at edge N produces `gnt` valid after edge N. It is visible in the cycle following the request cycle.
- Release latency: the request is seen low at edge N; `gnt` is 0 after edge N.
- There is always exactly one IDLE cycle between consecutive grants, including back-to-back grants to the same requester.
- Reset asserted mid-grant: outputs clear immediately, without waiting for a clock edge. The first grant after reset is searched from `ptr`=0.
- Simultaneous events:
  - Owner drops `req` on the same edge the timeout fires: treated as a normal release, and `timeout` stays 0.
  - `rst_n` low overrides everything else.

## Configuration
- Macro `RR_ARB_TIMEOUT_EN`.
- Defined:
  - The hold counter clears on entry to GRANT and increments every GRANT cycle.
  - When the counter reaches MAX_HOLD-1 and `req[gnt_idx]`=1, the FSM goes to IDLE. Pointer update is the same as a normal release.
  - `timeout`=1 for exactly the following cycle.
  - The grant lasts exactly MAX_HOLD cycles.
- Undefined:
  - No counter is built, and grants are held indefinitely.
  - `timeout` is tied to 0; MAX_HOLD and HOLD_W have no effect.

## Structure
- Package `rr_arb_pkg` holds:
  - NUM_REQ=8 and IDX_W=3.
  - The FSM state type with the IDLE and GRANT encodings.
  - The round-robin search function (request vector and pointer in, winner index out).
- Sub-module: the existing `decoder_3to8` instance turns `gnt_idx` into the raw one-hot vector. The vector is then ANDed with `gnt_valid`.
- All control logic stays in `rr_arbiter_8`.

## Test plan
- Reset and enable: `rst_n`=0 then released with req=8'hFF, en=0 → gnt=0 and gnt_valid=0 for 5 cycles. Set en=1 → gnt=8'h01 and gnt_idx=0 one cycle later.
- Single request: req=8'h08 → gnt=8'h08 and gnt_idx=3 after one edge. Drop req → gnt=0 the next cycle. Then req=8'h09 → gnt=8'h01, because ptr=4 wraps to 0.
- Full round: req=8'hFF, each owner drops its bit for one cycle after a 2-cycle grant → grant order is idx 0,1,…,7,0. There is one idle cycle between each pair.
- Ignore non-owner changes: owner 2 is granted, req toggles 8'h04↔8'hFC → gnt stays 8'h04 until bit 2 clears.
- Timeout (RR_ARB_TIMEOUT_EN, MAX_HOLD=4): req=8'h03 held continuously → gnt=8'h01 for 4 cycles, then timeout=1 with gnt=0, then gnt=8'h02 for 4 cycles, and the pattern repeats. Without the macro → gnt=8'h01 forever and timeout=0.
- Asynchronous reset mid-grant: pulse rst_n low between clock edges while gnt=8'h20 → gnt, gnt_idx and gnt_valid read 0 before the next edge. With req=8'h20 still high, the next grant comes after the first edge following release, with the search starting from ptr=0.
